// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the ALU: a main/skid register pair that holds decoded
// operands so decode sees a registered ready, with flush and a saturating stall counter.
module alu_issue_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_LENGTH   = 4,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_src_a,
    input  logic [DATA_WIDTH-1:0]      in_src_b,
    input  logic [OPCODE_LENGTH-1:0]   in_operation,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
    input  logic                       in_reg_write,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      SrcA,
    output logic [DATA_WIDTH-1:0]      SrcB,
    output logic [OPCODE_LENGTH-1:0]   Operation,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd,
    output logic                       out_reg_write,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     src_a;
        logic [DATA_WIDTH-1:0]     src_b;
        logic [OPCODE_LENGTH-1:0]  operation;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
    } entry_t;

    state_t                     r_state;
    state_t                     w_state_next;
    entry_t                     r_main;
    entry_t                     r_skid;
    entry_t                     w_main_next;
    entry_t                     w_skid_next;
    entry_t                     w_in_entry;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_stall;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cycles;

    assign w_in_entry = '{src_a:     in_src_a,
                          src_b:     in_src_b,
                          operation: in_operation,
                          rd:        in_rd,
                          reg_write: in_reg_write};

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_stall    = r_out_valid && !out_ready;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;

        if (flush) begin
            // Flush wins over any handshake this cycle; main keeps its last value for the outputs.
            w_state_next = ST_EMPTY;
            w_skid_next  = '0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = ST_ONE;
                        w_main_next  = w_in_entry;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_next = w_in_entry;
                    end else if (w_in_fire) begin
                        w_state_next = ST_FULL;
                        w_skid_next  = w_in_entry;
                    end else if (w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_next = ST_ONE;
                        w_main_next  = r_skid;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            // NOTE: payload registers are reset too, because the ALU-facing outputs must read 0 in reset.
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_FULL);
            r_out_valid <= (w_state_next != ST_EMPTY);
            r_main      <= w_main_next;
            r_skid      <= w_skid_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_WIDTH'(1);
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign SrcA          = r_main.src_a;
    assign SrcB          = r_main.src_b;
    assign Operation     = r_main.operation;
    assign out_rd        = r_main.rd;
    assign out_reg_write = r_main.reg_write && r_out_valid;
    assign stall_cycles  = r_stall_cycles;

endmodule
